pong_game_ctrl: RTL and testbench

- Frame-rate game controller that sequences the Pong VGA renderer: owns ball and paddle positions, bounces, scoring and serve/game-over flow.
- Drives bola_x, bola_y, barra_e_y and barra_d_y into the renderer.
- Advances once per video frame on frame_tick, a one-cycle pulse generated from VSync in the renderer's pixel clock domain.

---
 rtl/pong_game_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game controller: owns the ball and paddle positions, bounces,
// scoring and the serve / play / game-over sequencing. Everything advances
// once per video frame on frame_tick and is presented from registers.
module pong_game_ctrl #(
    parameter int SCREEN_H     = 480,
    parameter int WALL_H       = 6,
    parameter int PAD_W        = 15,
    parameter int PAD_H        = 80,
    parameter int PAD_R_X      = 630,
    parameter int BALL_SZ      = 20,
    parameter int CENTER_X     = 310,
    parameter int CENTER_Y     = 230,
    parameter int PAD_STEP     = 4,
    parameter int BALL_STEP    = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       e_up,
    input  logic       e_dn,
    input  logic       d_up,
    input  logic       d_dn,
    output logic [9:0] bola_x,
    output logic [9:0] bola_y,
    output logic [9:0] barra_e_y,
    output logic [9:0] barra_d_y,
    output logic [3:0] score_e,
    output logic [3:0] score_d,
    output logic [2:0] state,
    output logic       game_over
);

    localparam logic [9:0] WALL_V     = 10'(WALL_H);
    localparam logic [9:0] PAD_W_V    = 10'(PAD_W);
    localparam logic [9:0] PAD_H_V    = 10'(PAD_H);
    localparam logic [9:0] PAD_R_V    = 10'(PAD_R_X);
    localparam logic [9:0] BALL_V     = 10'(BALL_SZ);
    localparam logic [9:0] SCREEN_V   = 10'(SCREEN_H);
    localparam logic [9:0] CX_V       = 10'(CENTER_X);
    localparam logic [9:0] CY_V       = 10'(CENTER_Y);
    localparam logic [9:0] PSTEP_V    = 10'(PAD_STEP);
    localparam logic [9:0] BSTEP_V    = 10'(BALL_STEP);
    localparam logic [9:0] PAD_MAX_V  = 10'(SCREEN_H - PAD_H);
    localparam logic [9:0] BALL_MAXY  = 10'(SCREEN_H - BALL_SZ);
    localparam logic [9:0] BALL_STOPR = 10'(PAD_R_X - BALL_SZ);
    localparam logic [9:0] PAD_RESET  = 10'd200;
    localparam logic [7:0] SERVE_V    = 8'(SERVE_FRAMES);
    localparam logic [3:0] WIN_V      = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t     st;
    logic       dir_x_right;
    logic       dir_y_down;
    logic [7:0] serve_cnt;

    logic [9:0] pad_e_next;
    logic [9:0] pad_d_next;
    logic [9:0] ball_x_next;
    logic [9:0] ball_y_next;
    logic       dir_x_next;
    logic       dir_y_next;
    logic       hit_e;
    logic       hit_d;
    logic       miss_e;
    logic       miss_d;

    // Paddle step with clamping; the top clamp is tested before subtracting
    // so the unsigned position can never wrap below zero.
    function automatic logic [9:0] pad_next(input logic [9:0] y,
                                            input logic up,
                                            input logic dn);
        logic [9:0] r;
        r = y;
        if (up && !dn) begin
            r = (y < WALL_V + PSTEP_V) ? WALL_V : y - PSTEP_V;
        end else if (dn && !up) begin
            r = (y + PSTEP_V > PAD_MAX_V) ? PAD_MAX_V : y + PSTEP_V;
        end
        return r;
    endfunction

    assign pad_e_next = pad_next(barra_e_y, e_up, e_dn);
    assign pad_d_next = pad_next(barra_d_y, d_up, d_dn);

    // Candidate ball motion for a PLAY tick; both axes resolved independently
    // and collision tests use the paddle positions before this frame's move.
    always_comb begin
        ball_y_next = bola_y;
        dir_y_next  = dir_y_down;
        ball_x_next = bola_x;
        dir_x_next  = dir_x_right;
        miss_e      = 1'b0;
        miss_d      = 1'b0;
        hit_e       = (bola_y + BALL_V > barra_e_y) && (bola_y < barra_e_y + PAD_H_V);
        hit_d       = (bola_y + BALL_V > barra_d_y) && (bola_y < barra_d_y + PAD_H_V);

        if (dir_y_down) begin
            if (bola_y + BALL_V + BSTEP_V > SCREEN_V) begin
                ball_y_next = BALL_MAXY;
                dir_y_next  = 1'b0;
            end else begin
                ball_y_next = bola_y + BSTEP_V;
            end
        end else begin
            if (bola_y < WALL_V + BSTEP_V) begin
                ball_y_next = WALL_V;
                dir_y_next  = 1'b1;
            end else begin
                ball_y_next = bola_y - BSTEP_V;
            end
        end

        if (!dir_x_right) begin
            if (bola_x < PAD_W_V + BSTEP_V) begin
                if (hit_e) begin
                    ball_x_next = PAD_W_V;
                    dir_x_next  = 1'b1;
                end else begin
                    miss_e = 1'b1;
                end
            end else begin
                ball_x_next = bola_x - BSTEP_V;
            end
        end else begin
            if (bola_x + BALL_V + BSTEP_V > PAD_R_V) begin
                if (hit_d) begin
                    ball_x_next = BALL_STOPR;
                    dir_x_next  = 1'b0;
                end else begin
                    miss_d = 1'b1;
                end
            end else begin
                ball_x_next = bola_x + BSTEP_V;
            end
        end
    end

    // Game sequencer and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            bola_x      <= CX_V;
            bola_y      <= CY_V;
            barra_e_y   <= PAD_RESET;
            barra_d_y   <= PAD_RESET;
            score_e     <= 4'd0;
            score_d     <= 4'd0;
            dir_x_right <= 1'b1;
            dir_y_down  <= 1'b1;
            serve_cnt   <= 8'd0;
            game_over   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (frame_tick) begin
                        barra_e_y <= pad_e_next;
                        barra_d_y <= pad_d_next;
                    end
                    if (start) begin
                        st        <= SERVE;
                        serve_cnt <= SERVE_V;
                        score_e   <= 4'd0;
                        score_d   <= 4'd0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        barra_e_y <= pad_e_next;
                        barra_d_y <= pad_d_next;
                        if (serve_cnt == 8'd0) begin
                            st <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt - 8'd1;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        barra_e_y  <= pad_e_next;
                        barra_d_y  <= pad_d_next;
                        bola_y     <= ball_y_next;
                        dir_y_down <= dir_y_next;
                        bola_x      <= ball_x_next;
                        dir_x_right <= dir_x_next;
                        if (miss_e) begin
                            score_d <= score_d + 4'd1;
                            st      <= POINT;
                        end else if (miss_d) begin
                            score_e <= score_e + 4'd1;
                            st      <= POINT;
                        end
                    end
                end
                POINT: begin
                    if (frame_tick) begin
                        bola_x <= CX_V;
                        bola_y <= CY_V;
                        if (score_e == WIN_V || score_d == WIN_V) begin
                            st        <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            dir_y_down <= 1'b1;
                            serve_cnt  <= SERVE_V;
                            st         <= SERVE;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start) begin
                        score_e     <= 4'd0;
                        score_d     <= 4'd0;
                        serve_cnt   <= SERVE_V;
                        dir_x_right <= 1'b1;
                        game_over   <= 1'b0;
                        st          <= SERVE;
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: randomized button/tick/start traffic checked
// every cycle against a behavioural model of the game rules, plus directed
// serve timing and asynchronous mid-game reset checks.
module tb_pong_game_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic       e_up, e_dn, d_up, d_dn;
    logic [9:0] bola_x, bola_y, barra_e_y, barra_d_y;
    logic [3:0] score_e, score_d;
    logic [2:0] state;
    logic       game_over;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Behavioural model of the game
    int m_bx, m_by, m_pe, m_pd, m_se, m_sd, m_st, m_cnt;
    bit m_right, m_down;

    pong_game_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .start     (start),
        .e_up      (e_up),
        .e_dn      (e_dn),
        .d_up      (d_up),
        .d_dn      (d_dn),
        .bola_x    (bola_x),
        .bola_y    (bola_y),
        .barra_e_y (barra_e_y),
        .barra_d_y (barra_d_y),
        .score_e   (score_e),
        .score_d   (score_d),
        .state     (state),
        .game_over (game_over)
    );

    // Free-running pixel clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".bola_x"},    32'(bola_x),    32'(m_bx));
        checkValue({tag, ".bola_y"},    32'(bola_y),    32'(m_by));
        checkValue({tag, ".barra_e_y"}, 32'(barra_e_y), 32'(m_pe));
        checkValue({tag, ".barra_d_y"}, 32'(barra_d_y), 32'(m_pd));
        checkValue({tag, ".score_e"},   32'(score_e),   32'(m_se));
        checkValue({tag, ".score_d"},   32'(score_d),   32'(m_sd));
        checkValue({tag, ".state"},     32'(state),     32'(m_st));
        checkValue({tag, ".game_over"}, 32'(game_over), 32'(m_st == 4));
    endtask

    task automatic modelReset();
        m_bx = 310; m_by = 230; m_pe = 200; m_pd = 200;
        m_se = 0; m_sd = 0; m_st = 0; m_cnt = 0;
        m_right = 1'b1; m_down = 1'b1;
    endtask

    function automatic int paddleMove(int y, bit up, bit dn);
        int t;
        t = y;
        if (up && !dn) t = y - 4;
        if (dn && !up) t = y + 4;
        if (t < 6) t = 6;
        if (t > 400) t = 400;
        return t;
    endfunction

    function automatic bit overlaps(int ball_y, int pad_y);
        return (ball_y < pad_y + 80) && (pad_y < ball_y + 20);
    endfunction

    // One clock of the game rules, using values from before the edge
    task automatic modelStep(input bit tick, input bit go, input bit eu, input bit ed,
                             input bit du, input bit dd);
        int old_pe, old_pd, nx, ny;
        old_pe = m_pe;
        old_pd = m_pd;
        if (tick && (m_st == 0 || m_st == 1 || m_st == 2)) begin
            m_pe = paddleMove(m_pe, eu, ed);
            m_pd = paddleMove(m_pd, du, dd);
        end
        case (m_st)
            0: if (go) begin m_st = 1; m_cnt = 60; m_se = 0; m_sd = 0; end
            1: if (tick) begin
                   if (m_cnt == 0) m_st = 2;
                   else m_cnt--;
               end
            2: if (tick) begin
                   nx = m_bx + (m_right ? 2 : -2);
                   ny = m_by + (m_down ? 2 : -2);
                   if (!m_right && nx < 15) begin
                       if (overlaps(m_by, old_pe)) begin m_bx = 15; m_right = 1'b1; end
                       else begin m_sd++; m_st = 3; end
                   end else if (m_right && nx + 20 > 630) begin
                       if (overlaps(m_by, old_pd)) begin m_bx = 610; m_right = 1'b0; end
                       else begin m_se++; m_st = 3; end
                   end else begin
                       m_bx = nx;
                   end
                   if (ny + 20 > 480) begin m_by = 460; m_down = 1'b0; end
                   else if (ny < 6) begin m_by = 6; m_down = 1'b1; end
                   else m_by = ny;
               end
            3: if (tick) begin
                   m_bx = 310; m_by = 230;
                   if (m_se == 9 || m_sd == 9) m_st = 4;
                   else begin m_down = 1'b1; m_cnt = 60; m_st = 1; end
               end
            4: if (go) begin m_se = 0; m_sd = 0; m_cnt = 60; m_right = 1'b1; m_st = 1; end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input bit tick, input bit go, input bit eu, input bit ed,
                                 input bit du, input bit dd, input string tag);
        frame_tick = tick; start = go;
        e_up = eu; e_dn = ed; d_up = du; d_dn = dd;
        @(posedge clk);
        modelStep(tick, go, eu, ed, du, dd);
        #1;
        checkOutput(tag);
    endtask

    function automatic logic [1:0] trackButtons(int pad, int ball);
        int pc, bc;
        pc = pad + 40;
        bc = ball + 10;
        if (pc < bc - 4) return 2'b01;
        if (pc > bc + 4) return 2'b10;
        return 2'b00;
    endfunction

    // Directed sequence followed by randomized play
    initial begin
        logic [1:0] eb, db;
        int model_games, dut_games, cyc;
        bit prev_go, strong_left;

        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        e_up = 1'b0; e_dn = 1'b0; d_up = 1'b0; d_dn = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        rst = 1'b0;

        // Serve timing from IDLE
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "start");
        checkValue("start_state", 32'(state), 32'd1);
        for (int i = 0; i < 61; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "serve");
        checkValue("serve_done_state", 32'(state), 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "first_move");
        checkValue("first_move_x", 32'(bola_x), 32'd312);
        checkValue("first_move_y", 32'(bola_y), 32'd232);

        // Randomized games: one skilled player, one flailing player, swapped per game
        model_games = 0; dut_games = 0; cyc = 0; prev_go = 1'b0;
        while (model_games < 2 && cyc < 60000) begin
            strong_left = (model_games == 0);
            if (strong_left) begin
                eb = ($urandom_range(0, 99) < 85) ? trackButtons(m_pe, m_by) : 2'($urandom_range(0, 3));
                db = 2'($urandom_range(0, 3));
            end else begin
                db = ($urandom_range(0, 99) < 85) ? trackButtons(m_pd, m_by) : 2'($urandom_range(0, 3));
                eb = 2'($urandom_range(0, 3));
            end
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                          eb[1], eb[0], db[1], db[0], "random");
            if (m_st == 4 && !prev_go) model_games++;
            if (game_over === 1'b1 && !prev_go) dut_games++;
            prev_go = game_over;
            cyc++;
        end
        checkValue("games_completed", 32'(dut_games), 32'd2);

        // Restart from wherever the game stands and get the ball moving
        while (m_st != 2 && cyc < 62000) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "restart");
            cyc++;
        end
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "pre_reset");

        // Asynchronous reset between edges while playing
        #2;
        rst = 1'b1;
        frame_tick = 1'b1;
        #1;
        modelReset();
        checkValue("async_rst_x",     32'(bola_x),    32'd310);
        checkValue("async_rst_y",     32'(bola_y),    32'd230);
        checkValue("async_rst_pe",    32'(barra_e_y), 32'd200);
        checkValue("async_rst_pd",    32'(barra_d_y), 32'd200);
        checkValue("async_rst_se",    32'(score_e),   32'd0);
        checkValue("async_rst_sd",    32'(score_d),   32'd0);
        checkValue("async_rst_state", 32'(state),     32'd0);
        @(posedge clk);
        #1;
        checkOutput("tick_in_reset");
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
        checkValue("after_reset_state", 32'(state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
